// File: rtl/noc_pkg.sv
// Shared types and constants for the 2x2 mesh request scheduler.
package noc_pkg;

   localparam int unsigned NUM_PROC    = 4;
   localparam int unsigned PROC_ID_W   = 2;
   localparam int unsigned LEN_W       = 8;
   localparam int unsigned CFG_W       = 11;
   localparam int unsigned DONE_W      = 16;

   // configure bus layout: {len, dst, request}
   localparam int unsigned CFG_REQ_BIT = 0;
   localparam int unsigned CFG_DST_LSB = 1;
   localparam int unsigned CFG_LEN_LSB = CFG_DST_LSB + PROC_ID_W;

   typedef struct packed {
      logic [LEN_W-1:0]     len;
      logic [PROC_ID_W-1:0] dst;
   } desc_t;

   localparam int unsigned DESC_W = $bits(desc_t);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } chan_state_e;

   function automatic logic [CFG_W-1:0] make_cfg(input desc_t d, input logic req);
      logic [CFG_W-1:0] c;
      c                          = '0;
      c[CFG_REQ_BIT]             = req;
      c[CFG_DST_LSB +: PROC_ID_W] = d.dst;
      c[CFG_LEN_LSB +: LEN_W]     = d.len;
      return c;
   endfunction

endpackage

// File: rtl/noc_request_scheduler_if.sv
// Descriptor push port: valid/ready handshake plus the len==0 reject pulse.
interface noc_request_scheduler_if;
   import noc_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [PROC_ID_W-1:0] req_src;
   logic [PROC_ID_W-1:0] req_dst;
   logic [LEN_W-1:0]     req_len;
   logic                 req_reject;

   modport master (
      output req_valid, req_src, req_dst, req_len,
      input  req_ready, req_reject
   );

   modport slave (
      input  req_valid, req_src, req_dst, req_len,
      output req_ready, req_reject
   );

endinterface

// File: rtl/sched_fifo.sv
// Single-clock FIFO with full/empty flags; pushes while full and pops while empty are ignored.
module sched_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // storage needs no reset: occupancy alone defines validity
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/noc_request_scheduler.sv
// Per-processor descriptor queues and issue/ack/done channel FSMs for the 2x2 mesh.
// Optional macro SCHED_ACK_TIMEOUT_EN adds a per-channel acknowledge timeout.
module noc_request_scheduler
   import noc_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   noc_request_scheduler_if.slave push,
   input  logic [NUM_PROC-1:0]   processor_ready_signals,
   output logic [CFG_W-1:0]      p0_configure,
   output logic [CFG_W-1:0]      p1_configure,
   output logic [CFG_W-1:0]      p2_configure,
   output logic [CFG_W-1:0]      p3_configure,
   output logic [NUM_PROC-1:0]   busy,
   output logic [NUM_PROC-1:0]   err_timeout,
   output logic [DONE_W-1:0]     done_count
);

   localparam int unsigned INC_W = $clog2(NUM_PROC + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_param_check
      $error("noc_request_scheduler: DEPTH must be a power of two >= 2 and ACK_TIMEOUT >= 1");
   end

   logic [NUM_PROC-1:0] w_full;
   logic [NUM_PROC-1:0] w_done;
   logic [NUM_PROC-1:0] w_busy;
   logic [NUM_PROC-1:0] w_err;
   logic [CFG_W-1:0]    w_cfg [NUM_PROC];
   logic                w_handshake;
   logic                w_len_zero;
   logic                r_reject;
   logic [INC_W-1:0]    w_done_inc;
   logic [DONE_W-1:0]   r_done_count;

   assign push.req_ready = ~w_full[push.req_src];
   assign w_handshake    = push.req_valid && push.req_ready;
   assign w_len_zero     = (push.req_len == '0);

   always_ff @(posedge clock) begin
      if (reset) r_reject <= 1'b0;
      else       r_reject <= w_handshake && w_len_zero;
   end

   assign push.req_reject = r_reject;

   for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_chan
      desc_t            w_head;
      desc_t            w_in;
      logic             w_push;
      logic             w_pop;
      logic             w_empty;
      logic             w_full_l;
      logic             w_rdy;
      logic             w_timeout;
      logic             w_done_l;
      chan_state_e      r_state;
      chan_state_e      w_next;
      logic [CFG_W-1:0] r_cfg;
      logic [CFG_W-1:0] w_cfg_next;
      logic             r_busy;

      assign w_rdy  = processor_ready_signals[gi];
      assign w_in   = '{len: push.req_len, dst: push.req_dst};
      assign w_push = w_handshake && !w_len_zero && (push.req_src == PROC_ID_W'(gi));

      sched_fifo #(
         .DEPTH (DEPTH),
         .WIDTH (DESC_W)
      ) u_fifo (
         .clock   (clock),
         .reset   (reset),
         .i_push  (w_push),
         .i_data  (w_in),
         .i_pop   (w_pop),
         .o_head  (w_head),
         .o_full  (w_full_l),
         .o_empty (w_empty)
      );

`ifdef SCHED_ACK_TIMEOUT_EN
      localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
      logic [TO_W-1:0] r_to_cnt;
      logic            r_err;

      // counts completed WAIT_ACK cycles; fires on the last allowed one
      always_ff @(posedge clock) begin
         if (reset || r_state != WAIT_ACK) r_to_cnt <= '0;
         else                              r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      assign w_timeout = (r_state == WAIT_ACK) && w_rdy &&
                         (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));

      always_ff @(posedge clock) begin
         if (reset)          r_err <= 1'b0;
         else if (w_timeout) r_err <= 1'b1;
      end

      assign w_err[gi] = r_err;
`else
      assign w_timeout = 1'b0;
      assign w_err[gi] = 1'b0;
`endif

      // configure is registered, so it is computed for the state being entered
      always_comb begin
         w_next                  = r_state;
         w_cfg_next              = r_cfg;
         w_cfg_next[CFG_REQ_BIT] = 1'b0;
         w_pop                   = 1'b0;
         w_done_l                = 1'b0;
         case (r_state)
            IDLE: begin
               w_cfg_next = '0;
               if (!w_empty && w_rdy) begin
                  w_next     = ISSUE;
                  w_cfg_next = make_cfg(w_head, 1'b1);
               end
            end
            ISSUE: begin
               w_pop  = 1'b1;
               w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!w_rdy) begin
                  w_cfg_next = '0;
                  w_next     = WAIT_DONE;
               end else if (w_timeout) begin
                  w_cfg_next = '0;
                  w_next     = IDLE;
               end
            end
            WAIT_DONE: begin
               w_cfg_next = '0;
               if (w_rdy) begin
                  w_next   = IDLE;
                  w_done_l = 1'b1;
               end
            end
            default: begin
               w_cfg_next = '0;
               w_next     = IDLE;
            end
         endcase
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            r_state <= IDLE;
            r_cfg   <= '0;
            r_busy  <= 1'b0;
         end else begin
            r_state <= w_next;
            r_cfg   <= w_cfg_next;
            r_busy  <= (w_next != IDLE);
         end
      end

      assign w_full[gi] = w_full_l;
      assign w_done[gi] = w_done_l;
      assign w_busy[gi] = r_busy;
      assign w_cfg[gi]  = r_cfg;
   end

   // several channels may finish together: add the popcount
   always_comb begin
      w_done_inc = '0;
      for (int k = 0; k < NUM_PROC; k++) begin
         w_done_inc = w_done_inc + INC_W'(w_done[k]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_done_count <= '0;
      else       r_done_count <= r_done_count + DONE_W'(w_done_inc);
   end

   assign done_count   = r_done_count;
   assign busy         = w_busy;
   assign err_timeout  = w_err;
   assign p0_configure = w_cfg[0];
   assign p1_configure = w_cfg[1];
   assign p2_configure = w_cfg[2];
   assign p3_configure = w_cfg[3];

endmodule

// File: tb/tb_noc_request_scheduler.sv
// Directed self-checking bench for noc_request_scheduler (default build, timeout feature off).
module tb_noc_request_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  ready;
   logic [10:0] p0_cfg, p1_cfg, p2_cfg, p3_cfg;
   logic [3:0]  busy;
   logic [3:0]  err;
   logic [15:0] done;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   noc_request_scheduler_if bus();

   noc_request_scheduler #(
      .DEPTH       (4),
      .ACK_TIMEOUT (16)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .push                    (bus),
      .processor_ready_signals (ready),
      .p0_configure            (p0_cfg),
      .p1_configure            (p1_cfg),
      .p2_configure            (p2_cfg),
      .p3_configure            (p3_cfg),
      .busy                    (busy),
      .err_timeout             (err),
      .done_count              (done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [1:0] src, input logic [1:0] dst, input logic [7:0] len);
      bus.req_valid = 1'b1;
      bus.req_src   = src;
      bus.req_dst   = dst;
      bus.req_len   = len;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      ready         = 4'h0;
      bus.req_valid = 1'b0;
      bus.req_src   = 2'd0;
      bus.req_dst   = 2'd0;
      bus.req_len   = 8'd0;
      tick();
      tick();
      checks++;
      if ({p0_cfg, p1_cfg, p2_cfg, p3_cfg} !== 44'h0) begin
         errors++; $display("FAIL reset_cfg got %h want 0", {p0_cfg, p1_cfg, p2_cfg, p3_cfg});
      end
      checks++;
      if ({busy, err, done, bus.req_reject} !== 25'h0) begin
         errors++; $display("FAIL reset_status busy=%h err=%h done=%h rej=%b want all 0",
                            busy, err, done, bus.req_reject);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_single_transfer();
      logic [10:0] exp;
      ready         = 4'hF;
      bus.req_valid = 1'b1;
      bus.req_src   = 2'd0;
      bus.req_dst   = 2'd3;
      bus.req_len   = 8'd8;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL single_ready got %b want 1", bus.req_ready);
      end
      tick();
      bus.req_valid = 1'b0;
      checks++;
      if (p0_cfg !== 11'h0) begin
         errors++; $display("FAIL single_n1 got %h want 000", p0_cfg);
      end
      tick();
      exp = {8'd8, 2'd3, 1'b1};
      checks++;
      if (p0_cfg !== exp || busy[0] !== 1'b1) begin
         errors++; $display("FAIL single_issue cfg=%h busy0=%b want cfg=%h busy0=1", p0_cfg, busy[0], exp);
      end
      tick();
      exp = {8'd8, 2'd3, 1'b0};
      checks++;
      if (p0_cfg !== exp) begin
         errors++; $display("FAIL single_wait_ack got %h want %h", p0_cfg, exp);
      end
      ready[0] = 1'b0;
      tick();
      checks++;
      if (p0_cfg !== 11'h0) begin
         errors++; $display("FAIL single_wait_done got %h want 000", p0_cfg);
      end
      repeat (9) tick();
      checks++;
      if (busy[0] !== 1'b1 || done !== 16'd0) begin
         errors++; $display("FAIL single_pending busy0=%b done=%0d want busy0=1 done=0", busy[0], done);
      end
      ready[0] = 1'b1;
      tick();
      checks++;
      if (done !== 16'd1 || busy[0] !== 1'b0) begin
         errors++; $display("FAIL single_done done=%0d busy0=%b want done=1 busy0=0", done, busy[0]);
      end
   endtask

   task automatic test_fifo_full();
      logic [10:0] exp;
      logic        found;
      logic        extra;
      int          t;
      int          last;
      ready = 4'hD;
      for (int k = 0; k < 4; k++) begin
         bus.req_valid = 1'b1;
         bus.req_src   = 2'd1;
         bus.req_dst   = 2'(k);
         bus.req_len   = 8'(k + 1);
         #1;
         checks++;
         if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL fill_ready entry %0d got %b want 1", k, bus.req_ready);
         end
         tick();
      end
      bus.req_valid = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++; $display("FAIL full_src1_ready got %b want 0", bus.req_ready);
      end
      bus.req_src = 2'd2;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL full_src2_ready got %b want 1", bus.req_ready);
      end
      bus.req_src   = 2'd1;
      bus.req_len   = 8'd9;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      ready[1]      = 1'b1;
      last          = 0;
      for (int k = 0; k < 4; k++) begin
         found = 1'b0;
         t     = 0;
         while (!found && t < 12) begin
            tick();
            t++;
            if (p1_cfg[0] === 1'b1) found = 1'b1;
         end
         exp = {8'(k + 1), 2'(k), 1'b1};
         checks++;
         if (!found || p1_cfg !== exp) begin
            errors++; $display("FAIL drain_order entry %0d got %h want %h", k, p1_cfg, exp);
         end
         if (k > 0) begin
            checks++;
            if (cyc - last < 4) begin
               errors++; $display("FAIL drain_spacing entry %0d got %0d cycles want >=4", k, cyc - last);
            end
         end
         last = cyc;
         tick();
         checks++;
         if (p1_cfg[0] !== 1'b0) begin
            errors++; $display("FAIL drain_pulse entry %0d request still %b want 0", k, p1_cfg[0]);
         end
         ready[1] = 1'b0;
         tick();
         ready[1] = 1'b1;
      end
      extra = 1'b0;
      repeat (8) begin
         tick();
         if (p1_cfg[0] !== 1'b0) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++; $display("FAIL full_push_dropped got extra request %b want 0", extra);
      end
      checks++;
      if (done !== 16'd5) begin
         errors++; $display("FAIL drain_done got %0d want 5", done);
      end
   endtask

   task automatic test_len_zero();
      logic issued;
      ready         = 4'hF;
      bus.req_valid = 1'b1;
      bus.req_src   = 2'd2;
      bus.req_dst   = 2'd1;
      bus.req_len   = 8'd0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL zero_ready got %b want 1", bus.req_ready);
      end
      tick();
      bus.req_valid = 1'b0;
      checks++;
      if (bus.req_reject !== 1'b1) begin
         errors++; $display("FAIL zero_reject got %b want 1", bus.req_reject);
      end
      tick();
      checks++;
      if (bus.req_reject !== 1'b0) begin
         errors++; $display("FAIL zero_reject_once got %b want 0", bus.req_reject);
      end
      issued = 1'b0;
      repeat (6) begin
         tick();
         if (p2_cfg !== 11'h0 || busy[2] !== 1'b0) issued = 1'b1;
      end
      checks++;
      if (issued !== 1'b0) begin
         errors++; $display("FAIL zero_not_issued got activity %b want 0", issued);
      end
   endtask

   task automatic test_all_four(input logic [15:0] start, input logic [15:0] want);
      logic [10:0] exp;
      ready = 4'h0;
      for (int s = 0; s < 4; s++) begin
         push(2'(s), 2'(3 - s), 8'(s + 16));
      end
      tick();
      checks++;
      if (busy !== 4'h0 || done !== start) begin
         errors++; $display("FAIL four_idle busy=%h done=%h want busy=0 done=%h", busy, done, start);
      end
      ready = 4'hF;
      tick();
      exp = {8'd18, 2'd1, 1'b1};
      checks++;
      if ({p3_cfg[0], p2_cfg[0], p1_cfg[0], p0_cfg[0]} !== 4'hF || p2_cfg !== exp) begin
         errors++; $display("FAIL four_issue req=%b p2=%h want req=1111 p2=%h",
                            {p3_cfg[0], p2_cfg[0], p1_cfg[0], p0_cfg[0]}, p2_cfg, exp);
      end
      tick();
      ready = 4'h0;
      tick();
      ready = 4'hF;
      tick();
      checks++;
      if (done !== want || busy !== 4'h0) begin
         errors++; $display("FAIL four_done done=%h busy=%h want done=%h busy=0", done, busy, want);
      end
   endtask

   task automatic test_wrap();
      force dut.r_done_count = 16'hFFFE;
      @(negedge clock);
      release dut.r_done_count;
      tick();
      checks++;
      if (done !== 16'hFFFE) begin
         errors++; $display("FAIL wrap_preload got %h want fffe", done);
      end
      test_all_four(16'hFFFE, 16'h0002);
   endtask

   task automatic test_reset_mid();
      logic [10:0] exp;
      logic        issued;
      ready = 4'h0;
      push(2'd0, 2'd1, 8'd5);
      push(2'd0, 2'd2, 8'd6);
      push(2'd3, 2'd0, 8'd7);
      ready = 4'h1;
      tick();
      exp = {8'd5, 2'd1, 1'b1};
      checks++;
      if (p0_cfg !== exp) begin
         errors++; $display("FAIL mid_issue got %h want %h", p0_cfg, exp);
      end
      tick();
      ready[0] = 1'b0;
      tick();
      checks++;
      if (busy !== 4'b0001) begin
         errors++; $display("FAIL mid_wait_done busy=%b want 0001", busy);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({p0_cfg, p1_cfg, p2_cfg, p3_cfg} !== 44'h0 ||
          {busy, err, done, bus.req_reject} !== 25'h0) begin
         errors++; $display("FAIL mid_reset_outputs cfg=%h busy=%h err=%h done=%h rej=%b want all 0",
                            {p0_cfg, p1_cfg, p2_cfg, p3_cfg}, busy, err, done, bus.req_reject);
      end
      reset  = 1'b0;
      ready  = 4'hF;
      issued = 1'b0;
      repeat (10) begin
         tick();
         if ({p3_cfg[0], p2_cfg[0], p1_cfg[0], p0_cfg[0]} !== 4'h0 || busy !== 4'h0) issued = 1'b1;
      end
      checks++;
      if (issued !== 1'b0 || done !== 16'd0) begin
         errors++; $display("FAIL mid_post_reset activity=%b done=%0d want 0 and 0", issued, done);
      end
   endtask

   initial begin
      test_reset();
      test_single_transfer();
      test_fifo_full();
      test_len_zero();
      test_all_four(16'd5, 16'd9);
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
